// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address/instruction widths, reset PC and fetch entry layout.
package cpu_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP  = 32'h0000_0004;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count; head word is read combinationally.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;

  // Storage, pointers and occupancy; flush only rewinds pointers, stale words are never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit_chk.sv
// Simulation checker for fetch-unit bookkeeping and memory response protocol.
module instr_fetch_unit_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic          rsp_valid_i,
  input logic [CW-1:0] inflight_i,
  input logic [CW-1:0] tag_count_i,
  input logic [CW-1:0] drop_i
);

  // Sample pre-edge state on every active clock while out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!rsp_valid_i || (inflight_i != '0))
        else $error("imem response arrived with no read outstanding");
      assert (tag_count_i == inflight_i)
        else $error("pc tag queue occupancy %0d differs from inflight %0d", tag_count_i, inflight_i);
      assert (drop_i <= inflight_i)
        else $error("drop %0d exceeds inflight %0d", drop_i, inflight_i);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word reads, tags in-order responses with
// their PC and queues them for decode. Redirects flush the queue and count off stale reads.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     tag_count_s;
  logic [CW:0]       credit_used_s;
  logic [ADDR_W-1:0] rsp_tag_s;
  fetch_entry_t      rsp_entry_s;
  fetch_entry_t      head_s;
  logic              req_fire_s;
  logic              rsp_take_s;
  logic              instr_push_s;
  logic              instr_pop_s;

  // Every queued or outstanding word holds a credit, so the instruction queue cannot overflow.
  assign credit_used_s  = {1'b0, inflight_q} + {1'b0, count_s};
  assign imem_req_valid = rst && (credit_used_s < (CW+1)'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  assign rsp_take_s   = imem_rsp_valid && (inflight_q != '0);
  assign instr_push_s = rsp_take_s && (drop_q == '0) && !redirect_valid;
  assign instr_pop_s  = if_valid && if_ready && !redirect_valid;
  assign rsp_entry_s  = {imem_rsp_data, rsp_tag_s};

  assign if_valid = (count_s != '0);
  assign if_instr = head_s.instr;
  assign if_pc    = head_s.pc;

  // Next PC and read bookkeeping; a redirect turns every read still outstanding into a drop.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      pc_d       = word_align(redirect_pc);
      inflight_d = inflight_q - CW'(rsp_take_s);
      drop_d     = inflight_q - CW'(rsp_take_s);
    end else begin
      if (req_fire_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      inflight_d = inflight_q + CW'(req_fire_s) - CW'(rsp_take_s);
      if (rsp_take_s && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Tag queue is never flushed: stale responses still retire their tags in order.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (req_fire_s),
    .wdata_i (pc_q),
    .pop_i   (rsp_take_s),
    .flush_i (1'b0),
    .rdata_o (rsp_tag_s),
    .count_o (tag_count_s)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (instr_push_s),
    .wdata_i (rsp_entry_s),
    .pop_i   (instr_pop_s),
    .flush_i (redirect_valid),
    .rdata_o (head_s),
    .count_o (count_s)
  );

  instr_fetch_unit_chk #(
    .CW (CW)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst),
    .rsp_valid_i (imem_rsp_valid),
    .inflight_i  (inflight_q),
    .tag_count_i (tag_count_s),
    .drop_i      (drop_q)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with random latency and an epoch-tagged
// reference of what decode must see, compared every cycle.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  logic [31:0] m_pc;
  int          epoch;
  int          cyc;
  int          last_due;
  int          lat_lo;
  int          lat_hi;
  int          n_assert;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_00A0 + {2'b00, a[31:2]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    expq.delete();
    m_pc  = RESET_PC;
    epoch = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(imem_req_valid), 64'(1'b0));
    check({tag, "_if_valid"},  64'(if_valid),       64'(1'b0));
    check({tag, "_if_instr"},  64'(if_instr),       64'(32'h0));
    check({tag, "_if_pc"},     64'(if_pc),          64'(32'h0));
  endtask

  // One clock: drive response, check outputs against the model, then advance the model.
  task automatic tick();
    bit    rsp;
    bit    exp_rv;
    bit    req_fire;
    int    due;
    mreq_t m;
    @(negedge clk);
    rsp = (rst === 1'b1) && (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(memq[0].addr) : $urandom();
    #1;
    exp_rv = ((memq.size() + expq.size()) < DEPTH) && !redirect_valid;
    check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) check("req_addr", 64'(imem_req_addr), 64'(m_pc));
    check("if_valid", 64'(if_valid), 64'(expq.size() != 0));
    if (expq.size() != 0) begin
      check("if_pc",    64'(if_pc),    64'(expq[0].pc));
      check("if_instr", 64'(if_instr), 64'(expq[0].instr));
    end
    req_fire = exp_rv && imem_req_ready;
    @(posedge clk);
    if (!redirect_valid && if_ready && expq.size() != 0) void'(expq.pop_front());
    if (rsp) begin
      m = memq.pop_front();
      if (!redirect_valid && m.epoch == epoch) expq.push_back('{pc: m.addr, instr: mem_word(m.addr)});
    end
    if (redirect_valid) begin
      expq.delete();
      epoch++;
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: m_pc, epoch: epoch, due: due});
      m_pc = m_pc + 32'd4;
    end
    cyc++;
    #1;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; last_due = 0;
    lat_lo = 2; lat_hi = 2;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("reset");

    // Release after a rising edge so the first modelled cycle is the first live one.
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Back-to-back fetch from RESET_PC, then streaming at latency 2.
    repeat (20) tick();

    // Decode stalled: credits cap outstanding+queued, nothing lost on release.
    if_ready = 1'b0;
    repeat (10) tick();
    check("stall_req_valid", 64'(imem_req_valid), 64'(1'b0));
    if_ready = 1'b1;
    repeat (10) tick();

    // Redirect to an unaligned target with two reads in flight.
    for (int i = 0; i < 20 && memq.size() != 2; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();

    // Redirect in the same cycle as a response and a valid decode entry.
    if_ready = 1'b0;
    for (int i = 0; i < 20 && !(memq.size() > 0 && memq[0].due <= cyc && expq.size() > 0); i++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF4;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    repeat (12) tick();

    // Mid-stream reset with three entries queued.
    if_ready = 1'b0;
    for (int i = 0; i < 20 && expq.size() != 3; i++) tick();
    rst = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; if_ready = 1'b1;
    repeat (10) tick();

    // Randomized traffic: backpressure both sides, latency 1..4, random redirects.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready       = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : $urandom();
      tick();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
